// File: rtl/serial_write_buffer.sv
// serial_write_buffer
// Parallel-to-serial transmitter. A word and a bit count are captured when a
// transfer starts; one valid bit is presented on out_line per write_sig strobe.
// done_sig reads 1 while idle and 0 while busy or held in reset.
//
// Handshake: start is a level request that is only honoured in IDLE (done_sig=1);
// the cycle in which done_sig=1 and start=1 is the accepting cycle, and data_in and
// write_count are captured on that edge. Once accepted, the transfer is owned by
// the block until done_sig returns to 1. write_sig is a per-bit strobe that only
// matters while bits remain.
module serial_write_buffer #(
  parameter int   BUF_SIZE   = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1,
  localparam int  CTR_SIZE   = $clog2(BUF_SIZE + 1)
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                write_sig,
  input  logic [BUF_SIZE-1:0] data_in,
  input  logic [CTR_SIZE-1:0] write_count,
  output logic                out_line,
  output logic                done_sig
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [CTR_SIZE-1:0] BUF_SIZE_C = CTR_SIZE'(BUF_SIZE);

  state_t              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [BUF_SIZE-1:0] shreg_q, shreg_d;
  logic                out_q, out_d;
  logic                done_q, done_d;

  // Load-side helpers: clamped count, aligned word and its first bit.
  logic [CTR_SIZE-1:0] n_clamped;
  logic [CTR_SIZE-1:0] pad_bits;
  logic [BUF_SIZE-1:0] load_word;
  logic                first_bit;
  // Shift-side helpers: register after one advance and the bit it exposes.
  logic [BUF_SIZE-1:0] shifted_word;
  logic                next_bit;

  // Clamp the requested count and align the valid bits so that the first bit
  // to send sits at the output end of the shift register.
  always_comb begin
    n_clamped = (write_count > BUF_SIZE_C) ? BUF_SIZE_C : write_count;
    pad_bits  = BUF_SIZE_C - n_clamped;
    if (LSB_FIRST) begin
      // Valid bits are the top n; bring data_in[BUF_SIZE-n] down to bit 0.
      load_word = data_in >> pad_bits;
      first_bit = load_word[0];
    end else begin
      // Valid bits are the low n; bring data_in[n-1] up to the MSB.
      load_word = data_in << pad_bits;
      first_bit = load_word[BUF_SIZE-1];
    end
  end

  // One-bit advance of the shift register towards the output end.
  always_comb begin
    if (LSB_FIRST) begin
      shifted_word = shreg_q >> 1;
      next_bit     = shreg_q[1];
    end else begin
      shifted_word = shreg_q << 1;
      next_bit     = shreg_q[BUF_SIZE-2];
    end
  end

  // Next-state and registered-output logic for the RESET/IDLE/WRITE machine.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    done_d  = done_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
        shreg_d = '0;
        out_d   = IDLE_LEVEL;
        done_d  = 1'b1;
      end
      ST_IDLE: begin
        out_d  = IDLE_LEVEL;
        done_d = 1'b1;
        if (start) begin
          state_d = ST_WRITE;
          ctr_d   = n_clamped;
          shreg_d = load_word;
          done_d  = 1'b0;
          // The first bit is already on the line in the first WRITE cycle.
          out_d   = (n_clamped != '0) ? first_bit : IDLE_LEVEL;
        end
      end
      ST_WRITE: begin
        done_d = 1'b0;
        if (ctr_q != '0) begin
          if (write_sig) begin
            shreg_d = shifted_word;
            ctr_d   = ctr_q - CTR_SIZE'(1);
            // The last bit stays put through the trailing ctr=0 cycle.
            if (ctr_q != CTR_SIZE'(1)) begin
              out_d = next_bit;
            end
          end
        end else begin
          state_d = ST_IDLE;
          out_d   = IDLE_LEVEL;
          done_d  = 1'b1;
        end
      end
      default: begin
        // Unused encoding: recover through RESET while reporting busy.
        state_d = ST_RESET;
        ctr_d   = '0;
        shreg_d = '0;
        out_d   = IDLE_LEVEL;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      ctr_q   <= '0;
      shreg_q <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out_line = out_q;
  assign done_sig = done_q;

endmodule

// File: doc/serial_write_buffer.md
SERIAL_WRITE_BUFFER -- requirements
Module: serial_write_buffer

Interface
REQ-001 Parameter BUF_SIZE, default 8: maximum number of bits per transfer; legal values are 2 or greater.
REQ-002 Parameter LSB_FIRST, default 0: 0 sends the most significant valid bit first; 1 sends the least significant valid bit first.
REQ-003 Parameter IDLE_LEVEL, default 1'b1: level driven on out_line whenever no transfer is active.
REQ-004 Local constant CTR_SIZE SHALL equal $clog2(BUF_SIZE+1).
REQ-005 Port sys_clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-008 Port write_sig, input, 1 bit: bit-advance strobe, synchronous to sys_clk, one cycle per bit.
REQ-009 Port data_in, input, BUF_SIZE bits: parallel word, sampled on the accepted start cycle.
REQ-010 Port write_count, input, CTR_SIZE bits: number of bits n to send, sampled on the accepted start cycle.
REQ-011 Port out_line, output, 1 bit: serial data line.
REQ-012 Port done_sig, output, 1 bit: 1 means idle or transfer complete; 0 means busy or in reset.

Function
REQ-013 States SHALL be RESET, IDLE and WRITE; any unused encoding SHALL go to RESET on the next edge with done_sig=0.
REQ-014 RESET state: clear the shift register and counter, set done_sig=1, drive out_line=IDLE_LEVEL, then go to IDLE on the next edge.
REQ-015 IDLE state with start=1: go to WRITE on the next edge with done_sig=0, ctr=n and the shift register loaded from data_in.
REQ-016 Clamp: n SHALL equal min(write_count, BUF_SIZE).
REQ-017 Valid bits when LSB_FIRST=0: data_in[n-1:0], sent in the order data_in[n-1] down to data_in[0].
REQ-018 Valid bits when LSB_FIRST=1: data_in[BUF_SIZE-1:BUF_SIZE-n], sent in the order data_in[BUF_SIZE-n] up to data_in[BUF_SIZE-1].
REQ-019 Loopback: the bit placement in REQ-017 and REQ-018 SHALL make the transmitter inverse to the serial read buffer with the same BUF_SIZE, LSB_FIRST and count.
REQ-020 First-bit setup: in the first WRITE cycle, when n>0, out_line SHALL already present the first valid bit, i.e. one cycle after start is accepted.
REQ-021 WRITE state with ctr≠0 and write_sig=1: advance the shift register by one bit, decrement ctr, and drive the next bit on out_line from the next cycle.
REQ-022 WRITE state with ctr≠0 and write_sig=0: hold out_line and ctr unchanged.
REQ-023 WRITE state with ctr=0: on the next edge set done_sig=1, out_line=IDLE_LEVEL and state=IDLE.
REQ-024 Last-bit hold: the last bit stays on out_line through the cycle of its write_sig strobe and the following ctr=0 cycle.
REQ-025 Completion latency: done_sig SHALL rise exactly 2 cycles after the n-th write_sig strobe.
REQ-026 Zero count: n=0 sends no bits; done_sig returns to 1 two cycles after start is accepted; out_line stays at IDLE_LEVEL.
REQ-027 Ignored inputs: start during WRITE or RESET has no effect; write_sig during IDLE or RESET has no effect.
REQ-028 Input stability: data_in and write_count changes after the start cycle SHALL NOT affect the transfer in progress.
REQ-029 Back-to-back: start=1 in the same cycle done_sig first reads 1 (IDLE) SHALL begin a new transfer.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of sys_clk, force state=RESET, done_sig=0, out_line=IDLE_LEVEL, ctr=0 and shift register=0.
REQ-031 After rst_n rises, done_sig SHALL go to 1 on the first clock edge, and start SHALL be accepted from the second edge.
REQ-032 Reset in the middle of a transfer SHALL abort it: no remaining bits are sent, and out_line returns to IDLE_LEVEL asynchronously.

Verification
REQ-033 BUF_SIZE=8, LSB_FIRST=0: start with data_in=8'hA5, count=8, write_sig every 3rd cycle -> out_line 1,0,1,0,0,1,0,1; done_sig=1 two cycles after the 8th strobe.
REQ-034 LSB_FIRST=1: data_in=8'hA5, count=8 -> out_line 1,0,1,0,0,1,0,1 (LSB first).
REQ-035 LSB_FIRST=0: data_in=8'h0B, count=4 -> out_line 1,0,1,1; count=0 -> no bits, done_sig=1 two cycles after start; count=15 -> clamped to 8 bits.
REQ-036 Loopback into a serial read buffer with the same parameters, random data and counts 1..8 -> the receiver's valid bits equal the transmitted valid bits.
REQ-037 rst_n pulled low after bit 3 between clock edges -> out_line=IDLE_LEVEL and done_sig=0 without a clock edge; done_sig=1 on the first edge after release.
REQ-038 start held high during WRITE and write_sig pulsed in IDLE -> no transfer restart and no shift; back-to-back start on the done cycle -> second word sent intact.
